run_control: RTL and testbench
==============================

Name: run_control

Overview:
- Replaces the board-level gated clock mux and free cycle counter with a clock-enable run controller. The processor then runs on the main clock and advances only on a one-cycle `cpu_enable` pulse.
- Supports single-step, free-run, run-N-cycles and run-to-breakpoint modes. It also generates a stretched processor reset and keeps a parametrised cycle count for the HEX display.
- Sits between the clock divider / one-pulse logic and the computer core.

Parameters:
- COUNT_WIDTH, 16, width of `cycle_count` and `run_count`.
- PC_WIDTH, 32, width of `pc` and `bp_pc`.
- RESET_CYCLES, 4, number of clocks `cpu_reset` is held high (minimum 1).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- soft_reset  in  1  synchronous re-reset request, one-cycle pulse.
- mode  in  2  0=STEP, 1=FREE, 2=RUN_N, 3=RUN_BP.
- tick  in  1  one-cycle pace pulse from the divider (e.g. 1 Hz).
- go  in  1  one-cycle debounced button pulse; step or start.
- stop  in  1  one-cycle halt request.
- run_count  in  COUNT_WIDTH  cycle budget for RUN_N.
- bp_pc  in  PC_WIDTH  breakpoint address.
- pc  in  PC_WIDTH  current processor PC.
- cpu_enable  out  1  one-cycle advance pulse to the core.
- cpu_reset  out  1  processor/register-file reset.
- cycle_count  out  COUNT_WIDTH  number of `cpu_enable` pulses since the last reset.
- running  out  1  high while in RUN.
- state  out  2  current FSM state, for LEDs.

Behaviour:
- States: RST=0, HALT=1, RUN=2.
- Reset values on async `reset`:
  - state=RST, `cpu_reset`=1, `cpu_enable`=0.
  - `cycle_count`=0, `running`=0.
  - internal `remaining`=0, `first`=0, `rst_cnt`=0.
- RST state:
  - Hold `cpu_reset`=1 for exactly RESET_CYCLES clocks, counted by `rst_cnt`.
  - Then go to HALT; `cpu_reset` goes 0 on the same edge.
  - `go`, `tick` and `stop` are ignored while in RST.
- `soft_reset`, in any state:
  - Next state is RST, `rst_cnt`=0, `cycle_count`=0.
  - `cpu_enable` is forced 0 in that cycle.
  - `soft_reset` has the highest priority of all synchronous inputs.
- HALT state:
  - STEP mode: `go` → `cpu_enable`=1 for one cycle (registered, 1-cycle latency); stay in HALT.
  - FREE mode: `go` → RUN.
  - RUN_N mode: `go` → load `remaining`=`run_count`, then enter RUN. If `run_count`==0, stay in HALT and issue no pulse.
  - RUN_BP mode: `go` → set `first`=1, then enter RUN.
- RUN state: on each `tick`, evaluate in this priority order:
  1. `stop` → HALT, no pulse.
  2. RUN_N with `remaining`==1 → issue pulse, `remaining`=0, go to HALT.
  3. RUN_N otherwise → issue pulse, `remaining`−1.
  4. RUN_BP with `pc`==`bp_pc` and `first`==0 → HALT, no pulse.
  5. Otherwise → issue pulse, `first`=0.
- Additional RUN rules:
  - `stop` without `tick` → HALT.
  - A `mode` change while in RUN → HALT on the next clock, no pulse. `mode` is registered each clock for compare.
  - STEP mode is never in RUN.
  - The first tick after `go` in RUN_BP always issues a pulse, so execution can continue past a breakpoint.
- Simultaneous events:
  - `go` in RUN is ignored.
  - `go` and `stop` together in HALT: `stop` wins, stay in HALT.
  - `tick` and `go` together in HALT: `go` is processed; the `tick` is not consumed as a pulse.
- `cycle_count`:
  - Increments by 1 on every issued `cpu_enable`, on the same edge the pulse is registered.
  - Wraps modulo 2^COUNT_WIDTH.
  - Only async `reset` and `soft_reset` clear it.
- `cpu_enable` is never high in two consecutive cycles.
- `cpu_enable` is never high while `cpu_reset`=1.
- All outputs are registered.

Decomposition:
- Package `run_control_pkg`:
  - mode encodings MODE_STEP, MODE_FREE, MODE_RUN_N, MODE_RUN_BP.
  - state encodings ST_RST, ST_HALT, ST_RUN.
- One sub-module, `reset_stretcher`: parametrised RESET_CYCLES counter producing `cpu_reset` and a `done` pulse. Its restart input is driven by `soft_reset`.
- The FSM, `remaining` counter and `cycle_count` stay in `run_control`.

Test Plan:
1. Reset timing: assert `reset`, release, RESET_CYCLES=4 → `cpu_reset` high for exactly 4 clocks after release; then state=HALT, `cycle_count`=0.
2. Single step: mode=STEP, three `go` pulses spaced 10 clocks apart → exactly 3 single-cycle `cpu_enable` pulses, each 1 clock after its `go`; `cycle_count`=3; state stays HALT.
3. Run-N: mode=RUN_N, `run_count`=5, `go`, `tick` every 8 clocks → 5 pulses, HALT after the 5th. A further 3 ticks give no pulses; `cycle_count`=5. With `run_count`=0, `go` → no pulse, stays HALT.
4. Breakpoint: mode=RUN_BP, `bp_pc`=0x0C, `pc` model +4 per pulse starting at 0 → pulses at pc=0,4,8; halt at pc=0x0C with `cycle_count`=3. A new `go` → the first tick issues a pulse at pc=0x0C.
5. Stop and mode change: in FREE mode, assert `stop` together with a `tick` → no pulse, HALT. Restart, then change mode to STEP mid-run → HALT next clock, no pulse.
6. Wrap and soft reset: COUNT_WIDTH=4, 17 pulses → `cycle_count`=1. `soft_reset` mid-RUN → `cpu_enable`=0 that cycle, RST for 4 clocks, `cycle_count`=0.

Source files
------------

// File: rtl/run_control_pkg.sv
// run_control_pkg
//   Shared encodings for the clock-enable run controller.
//   mode_t  : run mode selected by the front-panel switches.
//   state_t : controller state, also shown on the LEDs.
package run_control_pkg;

    typedef enum logic [1:0] {
        MODE_STEP   = 2'd0,
        MODE_FREE   = 2'd1,
        MODE_RUN_N  = 2'd2,
        MODE_RUN_BP = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/run_control_reset_stretcher.sv
// reset_stretcher
//   Holds cpu_reset high for RESET_CYCLES clocks after async reset or a
//   restart request, then releases it.
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-high reset
//   restart   in   synchronous restart (soft reset pulse)
//   cpu_reset out  stretched processor reset (registered)
//   done      out  high in the final held cycle; cpu_reset drops on the next edge
module reset_stretcher #(
    parameter int RESET_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic cpu_reset,
    output logic done
);

    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(RESET_CYCLES - 1);

    logic [CW-1:0] rst_cnt;
    logic          last;

    assign last = (rst_cnt == LAST);
    // Combinational so the FSM can leave RST on the same edge cpu_reset drops.
    assign done = cpu_reset & last & ~restart;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_cnt   <= '0;
            cpu_reset <= 1'b1;
        end else if (restart) begin
            rst_cnt   <= '0;
            cpu_reset <= 1'b1;
        end else if (cpu_reset) begin
            if (last) begin
                rst_cnt   <= '0;
                cpu_reset <= 1'b0;
            end else begin
                rst_cnt <= rst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_control.sv
// run_control
//   Clock-enable run controller. The core runs on the main clock and
//   advances only on a one-cycle cpu_enable pulse. Supports single-step,
//   free-run, run-N and run-to-breakpoint, plus a stretched cpu reset and a
//   wrapping count of issued pulses.
//
//   state | meaning
//   RST   | cpu_reset held, waiting for the stretcher to finish
//   HALT  | idle; go steps (STEP) or starts a run
//   RUN   | pulse on each tick until stop/limit/breakpoint/mode change
//
// Ports:
//   clock, reset       system clock, async active-high reset
//   soft_reset         synchronous re-reset pulse (highest priority)
//   mode               0=STEP 1=FREE 2=RUN_N 3=RUN_BP
//   tick, go, stop     one-cycle pace / start-step / halt pulses
//   run_count          budget for RUN_N
//   bp_pc, pc          breakpoint address and current core PC
//   cpu_enable         one-cycle advance pulse to the core
//   cpu_reset          processor reset
//   cycle_count        pulses issued since last reset (wraps)
//   running, state     status for LEDs
module run_control
    import run_control_pkg::*;
#(
    parameter int COUNT_WIDTH  = 16,
    parameter int PC_WIDTH     = 32,
    parameter int RESET_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   soft_reset,
    input  logic [1:0]             mode,
    input  logic                   tick,
    input  logic                   go,
    input  logic                   stop,
    input  logic [COUNT_WIDTH-1:0] run_count,
    input  logic [PC_WIDTH-1:0]    bp_pc,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   cpu_enable,
    output logic                   cpu_reset,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic                   running,
    output logic [1:0]             state
);

    state_t                 state_q, state_nx;
    mode_t                  mode_cur, mode_q;
    logic                   en_nx;
    logic                   first_q, first_nx;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_nx;
    logic                   rst_done;
    logic                   tick_ok;

    assign mode_cur = mode_t'(mode);
    assign state    = state_q;
    // A tick right after a pulse is dropped so pulses never abut.
    assign tick_ok  = tick & ~cpu_enable;

    reset_stretcher #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_reset_stretcher (
        .clock     (clock),
        .reset     (reset),
        .restart   (soft_reset),
        .cpu_reset (cpu_reset),
        .done      (rst_done)
    );

    always_comb begin
        state_nx     = state_q;
        en_nx        = 1'b0;
        remaining_nx = remaining_q;
        first_nx     = first_q;
        if (soft_reset) begin
            state_nx = ST_RST;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (rst_done) state_nx = ST_HALT;
                end
                ST_HALT: begin
                    if (go && !stop) begin
                        case (mode_cur)
                            MODE_STEP: en_nx = ~cpu_enable;
                            MODE_FREE: state_nx = ST_RUN;
                            MODE_RUN_N: begin
                                if (run_count != '0) begin
                                    remaining_nx = run_count;
                                    state_nx     = ST_RUN;
                                end
                            end
                            MODE_RUN_BP: begin
                                first_nx = 1'b1;
                                state_nx = ST_RUN;
                            end
                            default: state_nx = ST_HALT;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (stop || mode_cur != mode_q || mode_cur == MODE_STEP) begin
                        state_nx = ST_HALT;
                    end else if (tick_ok) begin
                        case (mode_cur)
                            MODE_RUN_N: begin
                                en_nx        = 1'b1;
                                remaining_nx = remaining_q - 1'b1;
                                if (remaining_q == COUNT_WIDTH'(1)) state_nx = ST_HALT;
                            end
                            MODE_RUN_BP: begin
                                // first lets the run step off a breakpoint it stopped on
                                if (pc == bp_pc && !first_q) begin
                                    state_nx = ST_HALT;
                                end else begin
                                    en_nx    = 1'b1;
                                    first_nx = 1'b0;
                                end
                            end
                            default: en_nx = 1'b1;
                        endcase
                    end
                end
                default: state_nx = ST_RST;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RST;
            cpu_enable  <= 1'b0;
            cycle_count <= '0;
            running     <= 1'b0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            mode_q      <= MODE_STEP;
        end else begin
            state_q     <= state_nx;
            cpu_enable  <= en_nx;
            running     <= (state_nx == ST_RUN);
            remaining_q <= remaining_nx;
            first_q     <= first_nx;
            mode_q      <= mode_cur;
            if (soft_reset) cycle_count <= '0;
            else if (en_nx) cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_run_control.sv
// tb_run_control
//   Directed bench for run_control (COUNT_WIDTH=4 so wrap is reachable).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_run_control;

    logic        clock;
    logic        reset;
    logic        soft_reset;
    logic [1:0]  mode;
    logic        tick;
    logic        go;
    logic        stop;
    logic [3:0]  run_count;
    logic [31:0] bp_pc;
    logic [31:0] pc;
    logic        cpu_enable;
    logic        cpu_reset;
    logic [3:0]  cycle_count;
    logic        running;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_total = 0;
    int viol = 0;
    logic prev_en = 1'b0;
    logic pc_clear = 1'b1;

    run_control #(
        .COUNT_WIDTH (4),
        .PC_WIDTH    (32),
        .RESET_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .mode       (mode),
        .tick       (tick),
        .go         (go),
        .stop       (stop),
        .run_count  (run_count),
        .bp_pc      (bp_pc),
        .pc         (pc),
        .cpu_enable (cpu_enable),
        .cpu_reset  (cpu_reset),
        .cycle_count(cycle_count),
        .running    (running),
        .state      (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Core model: PC advances by 4 per enable pulse; also counts pulses
    // and flags back-to-back pulses or pulses during cpu_reset.
    always @(negedge clock) begin
        if (pc_clear) pc = 32'd0;
        else if (cpu_enable) pc = pc + 32'd4;
        if (cpu_enable && (prev_en || cpu_reset)) viol = viol + 1;
        if (cpu_enable) pulse_total = pulse_total + 1;
        prev_en = cpu_enable;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge clock); go = 1'b1;
        @(negedge clock); go = 1'b0;
    endtask

    task automatic tick_once(output logic en);
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        en = cpu_enable;
    endtask

    task automatic soft_rst();
        @(negedge clock); soft_reset = 1'b1;
        @(negedge clock); soft_reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic en;
        int   hi;
        int   p0;
        logic [1:0] exp_pat [4];

        reset = 1'b1; soft_reset = 1'b0; mode = 2'd0; tick = 1'b0;
        go = 1'b0; stop = 1'b0; run_count = 4'd0; bp_pc = 32'd0;

        // 1. reset values and stretch length
        repeat (3) @(negedge clock);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_enable", 32'(cpu_enable), 32'd0);
        chk("rst_count", 32'(cycle_count), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        reset = 1'b0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_reset) hi++;
            @(negedge clock);
        end
        chk("rst_hold_clocks", 32'(hi), 32'd4);
        chk("rst_to_halt", 32'(state), 32'd1);
        chk("rst_count_after", 32'(cycle_count), 32'd0);

        // 2. single step
        p0 = pulse_total;
        for (int k = 0; k < 3; k++) begin
            pulse_go();
            chk("step_pulse", 32'(cpu_enable), 32'd1);
            @(negedge clock);
            chk("step_pulse_end", 32'(cpu_enable), 32'd0);
            repeat (8) @(negedge clock);
        end
        chk("step_npulses", 32'(pulse_total - p0), 32'd3);
        chk("step_count", 32'(cycle_count), 32'd3);
        chk("step_state", 32'(state), 32'd1);

        // 3. run-N
        soft_rst();
        chk("srst_count", 32'(cycle_count), 32'd0);
        mode = 2'd2; run_count = 4'd5;
        pulse_go();
        chk("runn_state", 32'(state), 32'd2);
        chk("runn_running", 32'(running), 32'd1);
        for (int i = 0; i < 8; i++) begin
            repeat (7) @(negedge clock);
            tick_once(en);
            chk("runn_tick", 32'(en), (i < 5) ? 32'd1 : 32'd0);
        end
        chk("runn_halt", 32'(state), 32'd1);
        chk("runn_count", 32'(cycle_count), 32'd5);
        run_count = 4'd0;
        pulse_go();
        chk("runn0_enable", 32'(cpu_enable), 32'd0);
        @(negedge clock);
        chk("runn0_state", 32'(state), 32'd1);

        // simultaneous events in HALT
        mode = 2'd1;
        @(negedge clock); go = 1'b1; stop = 1'b1;
        @(negedge clock); go = 1'b0; stop = 1'b0;
        chk("go_stop_state", 32'(state), 32'd1);
        @(negedge clock); go = 1'b1; tick = 1'b1;
        @(negedge clock); go = 1'b0; tick = 1'b0;
        chk("go_tick_state", 32'(state), 32'd2);
        chk("go_tick_enable", 32'(cpu_enable), 32'd0);
        @(negedge clock); stop = 1'b1;
        @(negedge clock); stop = 1'b0;
        chk("stop_state", 32'(state), 32'd1);
        chk("hold_count", 32'(cycle_count), 32'd5);

        // 4. breakpoint
        pc_clear = 1'b1;
        soft_rst();
        pc_clear = 1'b0;
        mode = 2'd3; bp_pc = 32'h0C;
        @(negedge clock);
        chk("bp_pc_start", pc, 32'd0);
        pulse_go();
        exp_pat[0] = 2'd1; exp_pat[1] = 2'd1; exp_pat[2] = 2'd1; exp_pat[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            repeat (7) @(negedge clock);
            tick_once(en);
            chk("bp_tick", 32'(en), 32'(exp_pat[i]));
        end
        @(negedge clock);
        chk("bp_halt", 32'(state), 32'd1);
        chk("bp_count", 32'(cycle_count), 32'd3);
        chk("bp_pc_halt", pc, 32'h0C);
        pulse_go();
        repeat (3) @(negedge clock);
        tick_once(en);
        chk("bp_resume_pulse", 32'(en), 32'd1);
        @(negedge clock); stop = 1'b1;
        @(negedge clock); stop = 1'b0;
        chk("bp_stop_state", 32'(state), 32'd1);
        chk("bp_count2", 32'(cycle_count), 32'd4);
        chk("bp_pc_after", pc, 32'h10);

        // 5. stop with tick, mode change
        mode = 2'd1;
        pulse_go();
        repeat (2) @(negedge clock);
        tick_once(en);
        chk("free_pulse", 32'(en), 32'd1);
        @(negedge clock); stop = 1'b1; tick = 1'b1;
        @(negedge clock); stop = 1'b0; tick = 1'b0;
        chk("stop_tick_enable", 32'(cpu_enable), 32'd0);
        chk("stop_tick_state", 32'(state), 32'd1);
        pulse_go();
        chk("restart_state", 32'(state), 32'd2);
        repeat (2) @(negedge clock);
        mode = 2'd0; tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        chk("modechg_state", 32'(state), 32'd1);
        chk("modechg_enable", 32'(cpu_enable), 32'd0);
        chk("modechg_running", 32'(running), 32'd0);
        chk("modechg_count", 32'(cycle_count), 32'd5);

        // 6. wrap and soft reset mid-run
        mode = 2'd1;
        soft_rst();
        pulse_go();
        for (int i = 0; i < 17; i++) begin
            tick_once(en);
            @(negedge clock);
        end
        chk("wrap_count", 32'(cycle_count), 32'd1);
        chk("wrap_running", 32'(running), 32'd1);
        @(negedge clock); soft_reset = 1'b1; tick = 1'b1;
        @(negedge clock); soft_reset = 1'b0; tick = 1'b0;
        chk("srst_enable", 32'(cpu_enable), 32'd0);
        chk("srst_state", 32'(state), 32'd0);
        chk("srst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("srst_count_clr", 32'(cycle_count), 32'd0);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (state == 2'd0) hi++;
            @(negedge clock);
        end
        chk("srst_rst_clocks", 32'(hi), 32'd4);
        chk("srst_halt", 32'(state), 32'd1);
        chk("pulse_rules", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
